// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to a synchronous
// instruction memory and buffers returned words in a small prefetch queue
// presented to decode over a valid/ready handshake.
module fetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] im_addr,
   output logic              im_rd_en,
   input  logic [15:0]       im_instr,
   output logic [15:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_vld,
   input  logic              instr_rdy,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              hlt
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] pc;
   logic              inflight;
   logic [ADDR_W-1:0] inflight_pc;
   logic [CW-1:0]     count;
   logic [15:0]       q_instr [DEPTH];
   logic [ADDR_W-1:0] q_pc    [DEPTH];

   logic              redir;
   logic              pop;
   logic              push;
   logic              issue;
   logic [CW:0]       used;
   logic [CW-1:0]     wr_idx;

   // Handshake, credit check and memory request. Slots in use count the
   // in-flight read so a returning word always finds a free entry.
   always_comb begin
      redir     = redirect & rst_n;
      instr_vld = (count != '0);
      pop       = instr_vld & instr_rdy & ~redir;
      push      = inflight & ~redir;
      used      = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
      issue     = rst_n & ~hlt & (redir | (used < (CW+1)'(DEPTH)));
      im_rd_en  = issue;
      im_addr   = (redir & ~hlt) ? redirect_pc : pc;
      wr_idx    = count - CW'(pop);
      instr     = q_instr[0];
      instr_pc  = q_pc[0];
   end

   // PC and in-flight tracking; a redirect restarts the stream at its target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         inflight <= issue;
         if (issue) inflight_pc <= im_addr;
         if (redir)
            pc <= hlt ? redirect_pc : redirect_pc + ADDR_W'(1);
         else if (issue)
            pc <= pc + ADDR_W'(1);
      end
   end

   // Prefetch queue with entry 0 as head: pops shift down, a returning word
   // lands just past the surviving entries. Head only moves on pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_instr[i] <= '0;
            q_pc[i]    <= '0;
         end
      end else if (redir) begin
         count <= '0;
      end else begin
         count <= count + CW'(push) - CW'(pop);
         if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               q_instr[i] <= q_instr[i+1];
               q_pc[i]    <= q_pc[i+1];
            end
         end
         if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (wr_idx == CW'(i)) begin
                  q_instr[i] <= im_instr;
                  q_pc[i]    <= inflight_pc;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table from reset, randomized traffic
// against a transaction-level model of issued reads, and a mid-run reset.
module tb_fetch_unit;

   localparam logic [15:0] RST_PC = 16'h0000;
   localparam int          DEPTH  = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] im_addr;
   logic        im_rd_en;
   logic [15:0] im_instr = '0;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_vld;
   logic        instr_rdy;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        hlt;

   int tests = 0;
   int fails = 0;

   fetch_unit #(.ADDR_W(16), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_rd_en(im_rd_en),
      .im_instr(im_instr), .instr(instr), .instr_pc(instr_pc),
      .instr_vld(instr_vld), .instr_rdy(instr_rdy), .redirect(redirect),
      .redirect_pc(redirect_pc), .hlt(hlt)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_f(input logic [15:0] a);
      return 16'hA000 + a;
   endfunction

   // synchronous instruction memory: data one cycle after the strobe
   always @(posedge clk) if (im_rd_en) im_instr <= mem_f(im_addr);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: FIFO of reads issued since the last flush, each with its issue
   // cycle. A read becomes visible at the head two cycles after issue.
   typedef struct { logic [15:0] addr; int cyc; } rd_t;
   rd_t         mq[$];
   logic [15:0] mpc;
   int          cyc;

   task automatic model_step();
      bit ev, pop, er;
      if (!rst_n) begin
         chk("rst_vld", instr_vld, 0);
         chk("rst_rd_en", im_rd_en, 0);
         chk("rst_addr", im_addr, RST_PC);
         chk("rst_instr", instr, 0);
         chk("rst_instr_pc", instr_pc, 0);
         mq.delete();
         mpc = RST_PC;
         cyc = 0;
         return;
      end
      ev = (mq.size() > 0) && (mq[0].cyc + 2 <= cyc);
      chk("m_vld", instr_vld, ev);
      if (ev && instr_vld) begin
         chk("m_instr_pc", instr_pc, mq[0].addr);
         chk("m_instr", instr, mem_f(mq[0].addr));
      end
      pop = ev && instr_rdy;
      if (redirect) er = !hlt;
      else          er = !hlt && ((mq.size() - int'(pop)) < DEPTH);
      chk("m_rd_en", im_rd_en, er);
      if (er && im_rd_en) chk("m_addr", im_addr, redirect ? redirect_pc : mpc);
      if (redirect) begin
         mq.delete();
         if (!hlt) begin
            mq.push_back('{redirect_pc, cyc});
            mpc = redirect_pc + 16'd1;
         end else begin
            mpc = redirect_pc;
         end
      end else begin
         if (pop) void'(mq.pop_front());
         if (er) begin
            mq.push_back('{mpc, cyc});
            mpc = mpc + 16'd1;
         end
      end
      cyc++;
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic rdy, red, hlt; logic [15:0] rpc;
      logic vld; logic [15:0] ipc, ins;
      logic rd, ca; logic [15:0] addr;
   } vec_t;

   function automatic vec_t mk(input logic rdy, red, input logic [15:0] rpc, input logic hl,
                               input logic vld, input logic [15:0] ipc, ins,
                               input logic rd, ca, input logic [15:0] addr);
      vec_t v;
      v.rdy = rdy; v.red = red; v.rpc = rpc; v.hlt = hl;
      v.vld = vld; v.ipc = ipc; v.ins = ins; v.rd = rd; v.ca = ca; v.addr = addr;
      return v;
   endfunction

   vec_t tbl[27];

   initial begin
      // cycle 0 is the first cycle after reset release
      tbl[0]  = mk(1,0,16'h0000,0, 0,16'h0000,16'h0000, 1,1,16'h0000);
      tbl[1]  = mk(1,0,16'h0000,0, 0,16'h0000,16'h0000, 1,1,16'h0001);
      for (int i = 2; i <= 6; i++)
         tbl[i] = mk(0,0,16'h0000,0, 1,16'h0000,16'hA000, 0,1,16'h0002);
      tbl[7]  = mk(1,0,16'h0000,0, 1,16'h0000,16'hA000, 1,1,16'h0002);
      tbl[8]  = mk(1,0,16'h0000,0, 1,16'h0001,16'hA001, 1,1,16'h0003);
      tbl[9]  = mk(1,1,16'h0040,0, 1,16'h0002,16'hA002, 1,1,16'h0040);
      tbl[10] = mk(1,0,16'h0000,0, 0,16'h0000,16'h0000, 1,1,16'h0041);
      tbl[11] = mk(1,0,16'h0000,0, 1,16'h0040,16'hA040, 1,1,16'h0042);
      tbl[12] = mk(0,0,16'h0000,0, 1,16'h0041,16'hA041, 0,1,16'h0043);
      tbl[13] = mk(0,0,16'h0000,1, 1,16'h0041,16'hA041, 0,1,16'h0043);
      tbl[14] = mk(1,0,16'h0000,1, 1,16'h0041,16'hA041, 0,1,16'h0043);
      tbl[15] = mk(1,0,16'h0000,1, 1,16'h0042,16'hA042, 0,1,16'h0043);
      tbl[16] = mk(1,0,16'h0000,1, 0,16'h0000,16'h0000, 0,1,16'h0043);
      tbl[17] = mk(1,0,16'h0000,0, 0,16'h0000,16'h0000, 1,1,16'h0043);
      tbl[18] = mk(1,0,16'h0000,0, 0,16'h0000,16'h0000, 1,1,16'h0044);
      tbl[19] = mk(1,1,16'hFFFF,0, 1,16'h0043,16'hA043, 1,1,16'hFFFF);
      tbl[20] = mk(1,0,16'h0000,0, 0,16'h0000,16'h0000, 1,1,16'h0000);
      tbl[21] = mk(1,0,16'h0000,0, 1,16'hFFFF,16'h9FFF, 1,1,16'h0001);
      tbl[22] = mk(1,0,16'h0000,0, 1,16'h0000,16'hA000, 1,1,16'h0002);
      tbl[23] = mk(1,1,16'h0100,1, 1,16'h0001,16'hA001, 0,0,16'h0000);
      tbl[24] = mk(1,0,16'h0000,0, 0,16'h0000,16'h0000, 1,1,16'h0100);
      tbl[25] = mk(1,0,16'h0000,0, 0,16'h0000,16'h0000, 1,1,16'h0101);
      tbl[26] = mk(1,0,16'h0000,0, 1,16'h0100,16'hA100, 1,1,16'h0102);

      rst_n = 1'b1; instr_rdy = 1'b0; redirect = 1'b0; redirect_pc = '0; hlt = 1'b0;
      mq.delete(); mpc = RST_PC; cyc = 0;
      #2 rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;

      // directed vectors: stream, backpressure, redirect, halt, wrap
      for (int i = 0; i < 27; i++) begin
         instr_rdy = tbl[i].rdy; redirect = tbl[i].red;
         redirect_pc = tbl[i].rpc; hlt = tbl[i].hlt;
         @(negedge clk);
         chk($sformatf("t%0d_vld", i), instr_vld, tbl[i].vld);
         if (tbl[i].vld) begin
            chk($sformatf("t%0d_instr_pc", i), instr_pc, tbl[i].ipc);
            chk($sformatf("t%0d_instr", i), instr, tbl[i].ins);
         end
         chk($sformatf("t%0d_rd_en", i), im_rd_en, tbl[i].rd);
         if (tbl[i].ca) chk($sformatf("t%0d_addr", i), im_addr, tbl[i].addr);
         model_step();
         @(posedge clk);
         #1;
      end

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         instr_rdy = ($urandom_range(0, 3) != 0);
         redirect  = ($urandom_range(0, 15) == 0);
         hlt       = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0:       redirect_pc = 16'hFFFF;
            1:       redirect_pc = 16'hFFFE;
            default: redirect_pc = 16'($urandom);
         endcase
         tick();
      end

      // reset in the middle of a stream
      redirect = 1'b0; hlt = 1'b0; instr_rdy = 1'b1;
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      chk("async_rst_vld", instr_vld, 0);
      chk("async_rst_rd_en", im_rd_en, 0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("restart_rd_en", im_rd_en, 1);
      chk("restart_addr", im_addr, RST_PC);
      model_step();
      @(posedge clk);
      #1;
      tick();
      @(negedge clk);
      chk("restart_vld", instr_vld, 1);
      chk("restart_pc", instr_pc, RST_PC);
      chk("restart_instr", instr, mem_f(RST_PC));
      model_step();
      @(posedge clk);
      #1;
      repeat (10) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
